// File: rtl/main_memory.sv
// main_memory: line-burst backing store behind the data cache.
// Ports: req_* line request, wdata_* write beats, rdata_* read beats, wr_done, busy.
module main_memory #(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        wr_done,
  output logic        busy
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int IW    = $clog2(LINE_WORDS);
  localparam int LW    = WA - IW;
  localparam int DEPTH = 1 << WA;

  localparam logic [3:0] RW_END =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [3:0] WW_END = 4'(LATENCY - 1);
  localparam logic [IW-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, RWAIT, RBURST, WRITE, WWAIT, WDONE
  } state_t;

  state_t state_q, state_d;

  logic [LW-1:0] line_q;
  logic [IW-1:0] idx_q;
  logic [3:0]    cnt_q;
  logic          tail_q;
  logic [WA-1:0] waddr;
  logic          beat_last;
  logic          wr_beat;

  logic [31:0] mem [DEPTH];

  // Byte offset and out-of-range bits take no part in addressing.
  logic unused_addr;
  assign unused_addr =
    ^{req_addr[31:ADDR_WIDTH], req_addr[IW+1:0]};

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign waddr     = {line_q, idx_q};
  assign beat_last = (idx_q == IDX_LAST);
  assign wr_beat   = (state_q == WRITE) && wdata_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write)         state_d = WRITE;
          else if (LATENCY == 1) state_d = RBURST;
          else                   state_d = RWAIT;
        end
      end
      RWAIT:  if (cnt_q == RW_END) state_d = RBURST;
      // tail_q holds one turnaround cycle after the final beat.
      RBURST: if (tail_q) state_d = IDLE;
      WRITE:  if (wdata_valid && beat_last) state_d = WWAIT;
      WWAIT:  if (cnt_q == WW_END) state_d = WDONE;
      WDONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      line_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tail_q      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      wr_done     <= (state_q == WWAIT) &&
                     (cnt_q == WW_END);
      unique case (state_q)
        IDLE: begin
          idx_q  <= '0;
          cnt_q  <= '0;
          tail_q <= 1'b0;
          if (req_valid) begin
            line_q <= req_addr[ADDR_WIDTH-1:IW+2];
          end
        end
        RWAIT: cnt_q <= cnt_q + 4'd1;
        RBURST: begin
          if (!tail_q) begin
            rdata       <= mem[waddr];
            rdata_valid <= 1'b1;
            rdata_last  <= beat_last;
            idx_q       <= idx_q + 1'b1;
            tail_q      <= beat_last;
          end
        end
        WRITE: begin
          cnt_q <= '0;
          if (wdata_valid) idx_q <= idx_q + 1'b1;
        end
        WWAIT: cnt_q <= cnt_q + 4'd1;
        default: ;
      endcase
    end
  end

  // Storage has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_beat) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: vectors, directed corner cases and random
// traffic against a word-array model of main_memory.
module tb_main_memory;

  localparam int AW    = 17;
  localparam int LW    = 4;
  localparam int LAT   = 3;

  typedef logic [31:0] line_t [LW];
  typedef struct {
    logic [31:0] addr;
    line_t       exp;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_last;
  logic        wr_done;
  logic        busy;

  logic [4:0]  ctrl;
  assign ctrl = {rdata_valid, rdata_last, wr_done,
                 req_ready, busy};

  always #5 clk = ~clk;

  main_memory #(
    .ADDR_WIDTH(AW),
    .LINE_WORDS(LW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .wdata_valid(wdata_valid),
    .wdata(wdata),
    .rdata_valid(rdata_valid),
    .rdata(rdata),
    .rdata_last(rdata_last),
    .wr_done(wr_done),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [int unsigned];
  int unsigned wlines [$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned line_base(
    input logic [31:0] a);
    int unsigned w;
    w = (a % (32'd1 << AW)) / 4;
    return (w / LW) * LW;
  endfunction

  task automatic do_write(input logic [31:0] addr,
                          input line_t d,
                          input int gaps [LW]);
    int unsigned b;
    b = line_base(addr);
    check("wr_ready", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = addr;
    wdata_valid = 1'b1;
    wdata       = 32'hDEAD_BEEF;
    tick;
    req_valid   = 1'b0;
    wdata_valid = 1'b0;
    check("wr_accept", {27'd0, ctrl}, 32'b00001);
    for (int i = 0; i < LW; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        wdata_valid = 1'b0;
        wdata = $urandom;
        tick;
      end
      wdata_valid = 1'b1;
      wdata = d[i];
      tick;
      model[b + i] = d[i];
    end
    wdata_valid = 1'b0;
    for (int t = 1; t <= LAT + 1; t++) begin
      logic [4:0] e;
      tick;
      e = {1'b0, 1'b0, t == LAT,
           t == LAT + 1, t != LAT + 1};
      check("wr_seq", {27'd0, ctrl}, {27'd0, e});
    end
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input line_t exp,
                         input bit hold,
                         input bit noise);
    check("rd_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    tick;
    if (!hold) req_valid = 1'b0;
    for (int t = 0; t <= LAT + LW; t++) begin
      logic [4:0] e;
      bit v;
      v = (t >= LAT) && (t < LAT + LW);
      e = {v, t == LAT + LW - 1, 1'b0,
           t == LAT + LW, t != LAT + LW};
      check("rd_ctrl", {27'd0, ctrl}, {27'd0, e});
      if (v) check("rd_data", rdata, exp[t - LAT]);
      if (t < LAT + LW) begin
        if (noise) begin
          wdata_valid = 1'($urandom_range(0, 1));
          wdata = $urandom;
        end
        tick;
      end
    end
    wdata_valid = 1'b0;
  endtask

  function automatic line_t model_line(
    input logic [31:0] addr);
    line_t r;
    int unsigned b;
    b = line_base(addr);
    for (int i = 0; i < LW; i++) r[i] = model[b + i];
    return r;
  endfunction

  initial begin
    rd_vec_t vecs [5];
    line_t d;
    int nog [LW];
    int gp [LW];

    vecs[0] = '{32'h0000_0014,
      '{32'h1004, 32'h1005, 32'h1006, 32'h1007}};
    vecs[1] = '{32'h0000_0000,
      '{32'h1000, 32'h1001, 32'h1002, 32'h1003}};
    vecs[2] = '{32'h0002_0010,
      '{32'h1004, 32'h1005, 32'h1006, 32'h1007}};
    vecs[3] = '{32'h0000_003C,
      '{32'h100C, 32'h100D, 32'h100E, 32'h100F}};
    vecs[4] = '{32'hFFFE_0028,
      '{32'h1008, 32'h1009, 32'h100A, 32'h100B}};
    nog = '{0, 0, 0, 0};

    rst         = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = 32'h0;
    wdata_valid = 1'b1;
    wdata       = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("rst_ctrl", {27'd0, ctrl}, 32'b00010);
      check("rst_rdata", rdata, 32'h0);
    end
    req_valid   = 1'b0;
    wdata_valid = 1'b0;
    rst         = 1'b1;
    tick;
    check("post_rst", {27'd0, ctrl}, 32'b00010);

    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < LW; i++)
        d[i] = 32'h1000 + 32'(l * LW + i);
      do_write(32'(l * 16), d, nog);
    end

    foreach (vecs[i])
      do_read(vecs[i].addr, vecs[i].exp, 1'b0, 1'b0);

    d  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    gp = '{0, 0, 1, 0};
    do_write(32'h40, d, gp);
    do_read(32'h4C,
      '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b0, 1'b0);

    do_read(32'h10, vecs[0].exp, 1'b1, 1'b1);
    do_read(32'h20, vecs[4].exp, 1'b0, 1'b0);
    do_read(32'h10, vecs[0].exp, 1'b0, 1'b0);
    do_read(32'h44,
      '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b0, 1'b0);

    d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    do_write(32'h80, d, nog);
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 32'h84;
    tick;
    req_valid   = 1'b0;
    wdata_valid = 1'b1;
    wdata       = 32'hC0;
    tick;
    wdata       = 32'hC1;
    tick;
    wdata       = 32'hC2;
    rst         = 1'b0;
    #1;
    check("mid_rst_ctrl", {27'd0, ctrl}, 32'b00010);
    check("mid_rst_rdata", rdata, 32'h0);
    tick;
    tick;
    check("mid_rst_hold", {27'd0, ctrl}, 32'b00010);
    wdata_valid = 1'b0;
    rst         = 1'b1;
    tick;
    check("mid_rst_rel", {27'd0, ctrl}, 32'b00010);
    do_read(32'h80,
      '{32'hC0, 32'hC1, 32'hB2, 32'hB3}, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int unsigned l;
      logic [31:0] a;
      if (wlines.size() == 0 || $urandom_range(0, 1) == 1) begin
        l = $urandom_range(64, 79);
        a = ($urandom & 32'hFFFE_0000) |
            32'(l * 16) | 32'($urandom_range(0, 15));
        for (int i = 0; i < LW; i++) begin
          d[i]  = $urandom;
          gp[i] = $urandom_range(0, 2);
        end
        do_write(a, d, gp);
        wlines.push_back(l);
      end else begin
        l = wlines[$urandom_range(0, wlines.size() - 1)];
        a = ($urandom & 32'hFFFE_0000) |
            32'(l * 16) | 32'($urandom_range(0, 15));
        do_read(a, model_line(a), 1'b0,
                1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

Word-addressed backing-store responder at the far end of the data cache's refill/write-back interface. It accepts one line request at a time from the cache controller in the memory stage. A read request returns a burst of LINE_WORDS words after a fixed access latency. A write request absorbs a burst of LINE_WORDS words and acknowledges completion after the same latency. The cache holds the pipeline stall asserted while this block is busy.

## Interface
Parameters:
- ADDR_WIDTH, 17, byte-address bits implemented; upper request address bits are ignored.
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
- LATENCY, 3, access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  cache presents a line request.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = write-back, 0 = refill read; sampled at acceptance.
- req_addr  in  32  byte address; the line base is req_addr[ADDR_WIDTH-1:0] with the low log2(LINE_WORDS*4) bits cleared.
- wdata_valid  in  1  write beat present; honoured only in WRITE.
- wdata  in  32  write beat data.
- rdata_valid  out  1  read beat valid.
- rdata  out  32  read beat data.
- rdata_last  out  1  marks the final read beat.
- wr_done  out  1  one-cycle write-completion pulse.
- busy  out  1  equals ~req_ready.

## Operation
- Storage is 2^(ADDR_WIDTH-2) words of 32 bits. The array is not cleared by reset and keeps its contents across resets.
- Acceptance: req_valid & req_ready at a rising edge. The block latches the line base and the direction at that edge. Outside IDLE, req_valid is ignored.
- FSM states:
  - IDLE: wait for a request. On a read, go to RWAIT. On a write, go to WRITE.
  - RWAIT: count LATENCY-1 cycles, then go to RBURST.
  - RBURST: emit LINE_WORDS beats in ascending word order from the line base, then go to IDLE.
  - WRITE: capture one beat on each edge where wdata_valid=1, into base+beat_idx, ascending. After the last beat, go to WWAIT.
  - WWAIT: count LATENCY cycles, then go to WDONE.
  - WDONE: assert wr_done for one cycle, then go to IDLE.
- Beat index is log2(LINE_WORDS) bits and is cleared at acceptance. Word address is line base + index; it never crosses the line. Address bits above ADDR_WIDTH alias (wrap modulo memory size).
- wdata_valid gaps in WRITE stall the write burst with no timeout. wdata_valid outside WRITE is ignored and writes nothing.
- rdata, rdata_valid, rdata_last, and wr_done are registered outputs.
- Read-after-write: a read accepted after wr_done returns the newly written data.
- Reset (rst=0 at any time, including mid-burst) has these effects:
  - The FSM goes to IDLE and the counters clear.
  - rdata_valid, rdata_last, and wr_done go to 0, and rdata goes to 0.
  - req_ready goes to 1 and busy to 0 once reset is released.
  - A partially written line keeps the beats already captured.

## Timing
- Reset values: req_ready=1, busy=0, rdata_valid=0, rdata=0, rdata_last=0, wr_done=0.
- Read accepted at edge 0:
  - req_ready falls after edge 0.
  - Beat k (k=0..LINE_WORDS-1) is valid after edge LATENCY+k.
  - rdata_last is high with beat LINE_WORDS-1.
  - req_ready returns high after edge LATENCY+LINE_WORDS.
- Write whose last beat is captured at edge E:
  - wr_done is high after edge E+LATENCY, for exactly one cycle.
  - req_ready returns high after edge E+LATENCY+1.
- Throughput:
  - The minimum spacing between accepted reads is LATENCY+LINE_WORDS+1 edges, counting the IDLE acceptance cycle.
  - The first write beat can be captured on the edge after acceptance.
- rdata_valid and wr_done are never high in the same cycle.

## Test plan
- Reset: hold rst=0 and drive req_valid=1 -> all outputs at their reset values and no acceptance. After rst=1, req_ready=1.
- Read with LATENCY=3, LINE_WORDS=4, memory preloaded with word i = 0x1000+i, read at req_addr=0x0000_0014 (line base 0x10) accepted at edge 0 -> rdata 0x1004..0x1007 after edges 3..6, rdata_last only with 0x1007, req_ready high after edge 7.
- Write then read: write 0xA0..0xA3 to 0x40 with one wdata_valid gap between beats 1 and 2 -> wr_done pulses 3 cycles after the last beat. A subsequent read of 0x4C returns 0xA0,0xA1,0xA2,0xA3.
- Busy protocol: hold req_valid=1 throughout a read -> no second acceptance before IDLE; the next acceptance occurs on the edge where req_ready=1. wdata_valid pulses during the read leave memory unchanged.
- Aliasing: read at 0x0002_0010 with ADDR_WIDTH=17 -> returns the same data as 0x0000_0010.
- Mid-burst reset: assert rst=0 after beat 1 of a write -> outputs at reset values and FSM in IDLE. Beats 0 and 1 are stored; words 2 and 3 are unchanged.
